// File: rtl/regbank_gumnut_pkg.sv
// rtl/regbank_gumnut_pkg.sv - shared types, default sizes and parity helper for the Gumnut register bank
package regbank_gumnut_pkg;

    typedef enum logic {
        RB_IDLE  = 1'b0,
        RB_CLEAR = 1'b1
    } rb_state_t;

    localparam int RB_DW    = 8;
    localparam int RB_DEPTH = 8;
    localparam int RB_NRD   = 2;

    // Callers zero-extend narrower data into the 64-bit argument.
    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/regbank_gumnut_rdport.sv
// rtl/regbank_gumnut_rdport.sv - one registered read port with write-first bypass; parity check under REGBANK_PARITY_EN
module regbank_gumnut_rdport
    import regbank_gumnut_pkg::*;
#(
    parameter int DW    = RB_DW,
    parameter int DEPTH = RB_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cen,
    input  logic [AW-1:0]             rs_i,
    input  logic [DEPTH-1:0][DW-1:0]  mem_i,
    input  logic [DEPTH-1:0]          valid_i,
`ifdef REGBANK_PARITY_EN
    input  logic [DEPTH-1:0]          par_i,
    output logic                      par_err_o,
`endif
    input  logic                      byp_en_i,
    input  logic [AW-1:0]             wr_addr_i,
    input  logic [DW-1:0]             wr_dat_i,
    output logic [DW-1:0]             rdat_o,
    output logic                      vld_o
);

    logic          hit;
    logic [DW-1:0] rdat_d, rdat_q;
    logic          vld_d, vld_q;

    assign hit    = byp_en_i && (wr_addr_i == rs_i);
    assign rdat_d = hit ? wr_dat_i : mem_i[rs_i];
    assign vld_d  = hit | valid_i[rs_i];

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdat_q <= '0;
            vld_q  <= 1'b0;
        end else if (cen) begin
            rdat_q <= rdat_d;
            vld_q  <= vld_d;
        end
    end

    assign rdat_o = rdat_q;
    assign vld_o  = vld_q;

`ifdef REGBANK_PARITY_EN
    logic [63:0] ext;
    logic        par_err_d, par_err_q;

    // Bypassed data never touched storage, so it cannot carry a parity error.
    always_comb begin
        ext           = '0;
        ext[DW-1:0]   = mem_i[rs_i];
        par_err_d     = !hit && (par_i[rs_i] != even_parity(ext));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            par_err_q <= 1'b0;
        end else if (cen) begin
            par_err_q <= par_err_d;
        end
    end

    assign par_err_o = par_err_q;
`endif

endmodule

// File: rtl/regbank_gumnut_mp.sv
// rtl/regbank_gumnut_mp.sv - multi-port register bank with bypass, valid bits and clear engine; parity under REGBANK_PARITY_EN
module regbank_gumnut_mp
    import regbank_gumnut_pkg::*;
#(
    parameter int DW    = RB_DW,
    parameter int DEPTH = RB_DEPTH,
    parameter int NRD   = RB_NRD,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic [NRD*AW-1:0] rs_i,
    input  logic [AW-1:0]     rd_i,
    input  logic [DW-1:0]     dat_i,
    input  logic              we,
    input  logic              clr_req,
    output logic              clr_busy,
`ifdef REGBANK_PARITY_EN
    output logic [NRD-1:0]    par_err_o,
`endif
    output logic [NRD*DW-1:0] Rs_o,
    output logic [NRD-1:0]    vld_o
);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [DEPTH-1:0]         valid_q;
    rb_state_t                state_q, state_d;
    logic [AW-1:0]            cnt_q, cnt_d;
    logic                     idle;
    logic                     last;

    assign idle = (state_q == RB_IDLE);
    assign last = (cnt_q == AW'(DEPTH - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (idle) begin
            if (clr_req) begin
                state_d = RB_CLEAR;
                cnt_d   = '0;
            end
        end else begin
            cnt_d = cnt_q + AW'(1);
            if (last) begin
                state_d = RB_IDLE;
            end
        end
    end

`ifdef REGBANK_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [63:0]      wr_ext;

    always_comb begin
        wr_ext         = '0;
        wr_ext[DW-1:0] = dat_i;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            par_q <= '0;
        end else if (cen) begin
            if (idle && we) begin
                par_q[rd_i] <= even_parity(wr_ext);
            end else if (!idle) begin
                par_q[cnt_q] <= 1'b0;
            end
        end
    end
`endif

    // Reset wins over cen so a stalled pipeline can still be cleared.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q   <= '0;
            valid_q <= '0;
            state_q <= RB_IDLE;
            cnt_q   <= '0;
        end else if (cen) begin
            if (idle) begin
                if (we) begin
                    mem_q[rd_i]   <= dat_i;
                    valid_q[rd_i] <= 1'b1;
                end
            end else begin
                mem_q[cnt_q]   <= '0;
                valid_q[cnt_q] <= 1'b0;
            end
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign clr_busy = !idle;

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        regbank_gumnut_rdport #(
            .DW    (DW),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rdport (
            .clk       (clk),
            .rst       (rst),
            .cen       (cen),
            .rs_i      (rs_i[k*AW +: AW]),
            .mem_i     (mem_q),
            .valid_i   (valid_q),
`ifdef REGBANK_PARITY_EN
            .par_i     (par_q),
            .par_err_o (par_err_o[k]),
`endif
            .byp_en_i  (we && idle),
            .wr_addr_i (rd_i),
            .wr_dat_i  (dat_i),
            .rdat_o    (Rs_o[k*DW +: DW]),
            .vld_o     (vld_o[k])
        );
    end

endmodule

// File: tb/tb_regbank_gumnut_mp.sv
// tb/tb_regbank_gumnut_mp.sv - scoreboard bench for regbank_gumnut_mp (default and DEPTH=16/NRD=3 builds)
module tb_regbank_gumnut_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default sizes
    logic        a_rst, a_cen, a_we, a_clr, a_busy;
    logic [5:0]  a_rs;
    logic [2:0]  a_rd;
    logic [7:0]  a_dat;
    logic [15:0] a_Rs;
    logic [1:0]  a_vld;

    // Instance B: DEPTH=16, NRD=3
    logic        b_rst, b_cen, b_we, b_clr, b_busy;
    logic [11:0] b_rs;
    logic [3:0]  b_rd;
    logic [7:0]  b_dat;
    logic [23:0] b_Rs;
    logic [2:0]  b_vld;

`ifdef REGBANK_PARITY_EN
    logic [1:0] a_perr;
    logic [2:0] b_perr;
`endif

    regbank_gumnut_mp u_a (
        .clk       (clk),
        .rst       (a_rst),
        .cen       (a_cen),
        .rs_i      (a_rs),
        .rd_i      (a_rd),
        .dat_i     (a_dat),
        .we        (a_we),
        .clr_req   (a_clr),
        .clr_busy  (a_busy),
`ifdef REGBANK_PARITY_EN
        .par_err_o (a_perr),
`endif
        .Rs_o      (a_Rs),
        .vld_o     (a_vld)
    );

    regbank_gumnut_mp #(.DW(8), .DEPTH(16), .NRD(3)) u_b (
        .clk       (clk),
        .rst       (b_rst),
        .cen       (b_cen),
        .rs_i      (b_rs),
        .rd_i      (b_rd),
        .dat_i     (b_dat),
        .we        (b_we),
        .clr_req   (b_clr),
        .clr_busy  (b_busy),
`ifdef REGBANK_PARITY_EN
        .par_err_o (b_perr),
`endif
        .Rs_o      (b_Rs),
        .vld_o     (b_vld)
    );

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model of instance A
    logic [7:0] m_mem [8];
    logic       m_vld [8];
    logic       m_busy;
    logic [2:0] m_cnt;
    logic [7:0] e_rs  [2];
    logic       e_vld [2];

    task automatic push(input string tag, input logic [31:0] e);
        exp_t x;
        x.tag = tag;
        x.exp = e;
        sbq.push_back(x);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t x;
        n_tests++;
        if (sbq.size() == 0) begin
            n_fail++;
            $display("FAIL sb_empty observed=%0h expected=none", obs);
        end else begin
            x = sbq.pop_front();
            assert (obs === x.exp) else begin
                n_fail++;
                $error("FAIL %s observed=%0h expected=%0h", x.tag, obs, x.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_a(input logic rstn, input logic cen, input logic we, input logic [2:0] rd,
                         input logic [7:0] dat, input logic [2:0] r0, input logic [2:0] r1,
                         input logic clr, input string tag);
        logic [2:0] rs [2];
        a_rst = rstn; a_cen = cen; a_we = we; a_rd = rd; a_dat = dat;
        a_rs = {r1, r0}; a_clr = clr;
        rs[0] = r0;
        rs[1] = r1;
        if (!rstn) begin
            for (int i = 0; i < 8; i++) begin
                m_mem[i] = 8'h00;
                m_vld[i] = 1'b0;
            end
            for (int k = 0; k < 2; k++) begin
                e_rs[k]  = 8'h00;
                e_vld[k] = 1'b0;
            end
            m_busy = 1'b0;
            m_cnt  = 3'd0;
        end else if (cen) begin
            for (int k = 0; k < 2; k++) begin
                if (!m_busy && we && rd == rs[k]) begin
                    e_rs[k]  = dat;
                    e_vld[k] = 1'b1;
                end else begin
                    e_rs[k]  = m_mem[rs[k]];
                    e_vld[k] = m_vld[rs[k]];
                end
            end
            if (!m_busy) begin
                if (we) begin
                    m_mem[rd] = dat;
                    m_vld[rd] = 1'b1;
                end
                if (clr) begin
                    m_busy = 1'b1;
                    m_cnt  = 3'd0;
                end
            end else begin
                m_mem[m_cnt] = 8'h00;
                m_vld[m_cnt] = 1'b0;
                if (m_cnt == 3'd7) m_busy = 1'b0;
                m_cnt = m_cnt + 3'd1;
            end
        end
        push({tag, ".busy"}, {31'd0, m_busy});
        push({tag, ".rs0"},  {24'd0, e_rs[0]});
        push({tag, ".vld0"}, {31'd0, e_vld[0]});
        push({tag, ".rs1"},  {24'd0, e_rs[1]});
        push({tag, ".vld1"}, {31'd0, e_vld[1]});
        tick();
        pop_chk({31'd0, a_busy});
        pop_chk({24'd0, a_Rs[7:0]});
        pop_chk({31'd0, a_vld[0]});
        pop_chk({24'd0, a_Rs[15:8]});
        pop_chk({31'd0, a_vld[1]});
    endtask

    task automatic drive_b(input logic rstn, input logic we, input logic [3:0] rd,
                           input logic [7:0] dat, input logic [11:0] rs, input logic clr);
        b_rst = rstn; b_cen = 1'b1; b_we = we; b_rd = rd; b_dat = dat; b_rs = rs; b_clr = clr;
    endtask

    task automatic chk_b(input string tag, input logic busy, input logic [23:0] rs, input logic [2:0] vld);
        push({tag, ".busy"}, {31'd0, busy});
        push({tag, ".rs"},   {8'd0, rs});
        push({tag, ".vld"},  {29'd0, vld});
        tick();
        pop_chk({31'd0, b_busy});
        pop_chk({8'd0, b_Rs});
        pop_chk({29'd0, b_vld});
    endtask

    initial begin
        a_rst = 1'b0; a_cen = 1'b0; a_we = 1'b0; a_rd = '0; a_dat = '0; a_rs = '0; a_clr = 1'b0;
        b_rst = 1'b0; b_cen = 1'b0; b_we = 1'b0; b_rd = '0; b_dat = '0; b_rs = '0; b_clr = 1'b0;

        // Reset taken with cen low
        cyc_a(1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 3'd0, 3'd0, 1'b0, "rst_cen0");
        b_rst = 1'b1;
        cyc_a(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd0, 3'd7, 1'b0, "rst_read");

        // Write then read
        cyc_a(1'b1, 1'b1, 1'b1, 3'd3, 8'hA5, 3'd0, 3'd1, 1'b0, "wr3");
        cyc_a(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd3, 3'd4, 1'b0, "rd3");

        // Bypass on both ports
        cyc_a(1'b1, 1'b1, 1'b1, 3'd5, 8'h3C, 3'd5, 3'd5, 1'b0, "byp5");

        // cen low: write ignored, outputs hold
        cyc_a(1'b1, 1'b0, 1'b1, 3'd2, 8'h11, 3'd2, 3'd3, 1'b0, "cen0_wr2");
        cyc_a(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 3'd2, 3'd2, 1'b1, "cen0_clr");
        cyc_a(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'd2, 3'd3, 1'b0, "rd2");

        // Fill all entries; last write coincides with clr_req
        for (int i = 0; i < 7; i++) begin
            cyc_a(1'b1, 1'b1, 1'b1, 3'(i), 8'(8'h10 + i), 3'(i), 3'd5, 1'b0, $sformatf("fill%0d", i));
        end
        cyc_a(1'b1, 1'b1, 1'b1, 3'd7, 8'h17, 3'd7, 3'd0, 1'b1, "fill7_clr");

        // Sweep: reads of the entry being cleared see pre-clear data; write mid-sweep dropped
        for (int i = 0; i < 8; i++) begin
            cyc_a(1'b1, 1'b1, (i == 2), 3'd1, 8'h77, 3'(i), 3'(i + 7), 1'b0, $sformatf("sweep%0d", i));
        end
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 3'(2 * i), 3'(2 * i + 1), 1'b0, $sformatf("post%0d", i));
        end

        // Reset mid-sweep on the 16-deep, 3-port build
        a_cen = 1'b0;
        for (int i = 0; i < 16; i++) begin
            drive_b(1'b1, 1'b1, 4'(i), 8'(8'h40 + i), 12'h000, 1'b0);
            tick();
        end
        drive_b(1'b1, 1'b0, 4'd0, 8'h00, {4'd15, 4'd0, 4'd9}, 1'b0);
        chk_b("b_rd", 1'b0, {8'h4F, 8'h40, 8'h49}, 3'b111);
        drive_b(1'b1, 1'b0, 4'd0, 8'h00, {4'd15, 4'd0, 4'd9}, 1'b1);
        chk_b("b_clr", 1'b1, {8'h4F, 8'h40, 8'h49}, 3'b111);
        drive_b(1'b1, 1'b0, 4'd0, 8'h00, {4'd2, 4'd1, 4'd0}, 1'b0);
        chk_b("b_sw2", 1'b1, {8'h42, 8'h41, 8'h40}, 3'b111);
        drive_b(1'b1, 1'b0, 4'd0, 8'h00, {4'd2, 4'd1, 4'd0}, 1'b0);
        chk_b("b_sw3", 1'b1, {8'h42, 8'h41, 8'h00}, 3'b110);
        drive_b(1'b0, 1'b0, 4'd0, 8'h00, {4'd2, 4'd1, 4'd0}, 1'b0);
        chk_b("b_rst", 1'b0, 24'h0, 3'b000);
        for (int j = 0; j < 6; j++) begin
            drive_b(1'b1, 1'b0, 4'd0, 8'h00, {4'(3 * j + 2), 4'(3 * j + 1), 4'(3 * j)}, 1'b0);
            chk_b($sformatf("b_post%0d", j), 1'b0, 24'h0, 3'b000);
        end

        n_tests++;
        assert (sbq.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regbank_gumnut_mp.md
Name: regbank_gumnut_mp

Overview:
Parametrised multi-port register bank for the next-generation Gumnut datapath. It provides:
- NRD registered read ports and one write port.
- Write-to-read bypass.
- Per-entry valid bits.
- A hardware clear engine that walks the array one entry per cycle.

It sits between decode (read addresses) and writeback (write port). Advancing is qualified by cen, a clock enable rather than a gated clock.

Parameters:
DW, 8, data width in bits (1..64)
DEPTH, 8, number of registers; power of two, 2..256
NRD, 2, number of read ports (1..4)
AW, $clog2(DEPTH), address width (derived; do not override)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset, sampled on rising clk regardless of cen
cen  in  1  clock enable; when 0 all state holds, including the clear engine
rs_i  in  NRD*AW  read addresses, port k at bits [k*AW +: AW]
rd_i  in  AW  write address
dat_i  in  DW  write data
we  in  1  write enable
clr_req  in  1  start clear-all; level sampled in IDLE
clr_busy  out  1  clear engine active
Rs_o  out  NRD*DW  registered read data, port k at bits [k*DW +: DW]
vld_o  out  NRD  registered valid bit of addressed entry per port

Behaviour:
- Reset (rst=0 at a clk edge), regardless of cen:
  - all entries cleared to 0 and all valid bits cleared;
  - Rs_o=0, vld_o=0, clr_busy=0, state=IDLE, clear counter=0.
- Write, when cen=1, we=1 and state=IDLE: mem[rd_i]<=dat_i and valid[rd_i]<=1 at the edge.
- Read latency is 1 cycle. When cen=1, at each edge port k registers mem[rs_k] and valid[rs_k].
- Bypass: if we=1, state=IDLE and rd_i==rs_k in the same cycle, port k registers dat_i and vld=1 (write-first). All ports bypass independently.
- cen=0: mem, valid, Rs_o, vld_o, state and counter all hold; we and clr_req are ignored.
- Clear engine states, IDLE and CLEAR:
  - IDLE->CLEAR when cen=1 and clr_req=1. Counter loads 0, clr_busy=1 from the next cycle.
  - In CLEAR, each enabled cycle: mem[cnt]<=0, valid[cnt]<=0, cnt<=cnt+1.
  - CLEAR->IDLE on the cycle cnt==DEPTH-1 is cleared. clr_busy drops the following cycle, so it is high for exactly DEPTH enabled cycles.
  - clr_req while in CLEAR is ignored; no restart. A clr_req still high on return to IDLE starts a new sweep.
  - Writes during CLEAR are dropped, with no error indication.
  - Reads during CLEAR return current array contents; no bypass.
  - A read of the entry being cleared this cycle returns its pre-clear value.
- Simultaneous we=1 and clr_req=1 in IDLE: the write is performed and the clear starts next cycle, so the written entry is later cleared.
- Reset mid-CLEAR: the sweep is aborted and the whole array is cleared immediately by reset.
- Address arithmetic: addresses are unsigned AW bits and every value is legal, so there is no out-of-range case. Counter wrap is never reached because of the exit condition.

Optional Feature:
REGBANK_PARITY_EN
- Defined:
  - each entry stores an extra even-parity bit computed from dat_i on write; clear and reset store parity 0;
  - read ports recompute parity;
  - extra output par_err_o [NRD-1:0], registered with Rs_o, =1 when the stored bit mismatches recomputed parity;
  - the bypass path always reports par_err=0;
  - reset value of par_err_o is 0.
- Undefined: no parity storage and no par_err_o port.

Decomposition:
- Package regbank_gumnut_pkg:
  - typedef enum logic {RB_IDLE, RB_CLEAR} rb_state_t;
  - default constants RB_DW=8, RB_DEPTH=8, RB_NRD=2;
  - function even_parity.
- Sub-module regbank_gumnut_rdport, instantiated NRD times via generate: address mux, bypass compare, output register, parity check.

Test Plan:
- Reset with cen=0: drive rst=0 for one edge with cen=0 -> Rs_o=0, vld_o=0, clr_busy=0; array reads return 0 with vld=0.
- Write then read: write 0xA5 to addr 3; next cycle rs0=3 -> Rs_o port0=0xA5 one cycle later, vld=1.
- Bypass on two ports: we=1, rd_i=5, dat_i=0x3C, rs0=rs1=5 in the same cycle -> both ports show 0x3C, vld=1 next cycle.
- cen hold: write 0x11 to addr 2 with cen=0 -> no change; a later read of addr 2 returns 0, vld=0. Rs_o is unchanged while cen=0.
- Clear sweep: fill all 8 entries, pulse clr_req -> clr_busy high exactly 8 cycles. A write to addr 1 mid-sweep is dropped. After the sweep all reads are 0 with vld=0.
- Reset mid-CLEAR (cycle 3 of sweep), with DEPTH=16, NRD=3 build -> clr_busy=0 next cycle and all 16 entries read 0.
